// File: rtl/seq_detector.sv
// Serial 1011 pattern detector: 4-state FSM, registered one-cycle detect pulse,
// saturating match counter with synchronous clear. Overlap mode picked per match.
module seq_detector #(
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             din,
   input  logic             din_valid,
   input  logic             overlap_en,
   input  logic             clr_cnt,
   output logic             detect,
   output logic [1:0]       state,
   output logic [CNT_W-1:0] det_count,
   output logic             cnt_sat
);

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_S1   = 2'd1;
   localparam logic [1:0] ST_S10  = 2'd2;
   localparam logic [1:0] ST_S101 = 2'd3;

   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   logic [1:0]       r_state;
   logic [1:0]       w_state_nxt;
   logic             r_detect;
   logic [CNT_W-1:0] r_count;
   logic             r_sat;
   logic             w_match;

   // din is consumed only on edges with din_valid=1; otherwise everything holds.
   assign w_match = din_valid && din && (r_state == ST_S101);

   always_comb begin
      w_state_nxt = r_state;
      if (din_valid) begin
         case (r_state)
            ST_IDLE: w_state_nxt = din ? ST_S1 : ST_IDLE;
            ST_S1:   w_state_nxt = din ? ST_S1 : ST_S10;
            ST_S10:  w_state_nxt = din ? ST_S101 : ST_IDLE;
            ST_S101: begin
               if (!din)
                  w_state_nxt = ST_S10;
               else
                  w_state_nxt = overlap_en ? ST_S1 : ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state  <= ST_IDLE;
         r_detect <= 1'b0;
      end else begin
         r_state  <= w_state_nxt;
         r_detect <= w_match;
      end
   end

   // Clear has priority over a coincident match; the match still pulses detect.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_count <= '0;
         r_sat   <= 1'b0;
      end else if (clr_cnt) begin
         r_count <= '0;
         r_sat   <= 1'b0;
      end else if (w_match && !r_sat) begin
         r_count <= r_count + CNT_ONE;
         r_sat   <= (r_count == (CNT_MAX - CNT_ONE));
      end
   end

   assign detect    = r_detect;
   assign state     = r_state;
   assign det_count = r_count;
   assign cnt_sat   = r_sat;

endmodule

// File: tb/tb_seq_detector.sv
// Directed bench for seq_detector: vector table for the main flows, hand-written
// sequences for reset mid-pattern and counter saturation (CNT_W=2 instance).
module tb_seq_detector;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       din = 1'b0;
   logic       din_valid = 1'b0;
   logic       overlap_en = 1'b0;
   logic       clr_cnt = 1'b0;

   logic       detect8, sat8;
   logic [1:0] state8;
   logic [7:0] count8;
   logic       detect2, sat2;
   logic [1:0] state2;
   logic [1:0] count2;

   int total = 0;
   int bad   = 0;

   typedef struct {
      logic       d;
      logic       v;
      logic       ov;
      logic       clr;
      logic       exp_det;
      logic [1:0] exp_st;
      int         exp_cnt;
   } vec_t;

   vec_t tbl[$];

   seq_detector #(.CNT_W(8)) dut8 (
      .clk(clk), .rst(rst), .din(din), .din_valid(din_valid),
      .overlap_en(overlap_en), .clr_cnt(clr_cnt),
      .detect(detect8), .state(state8), .det_count(count8), .cnt_sat(sat8)
   );

   seq_detector #(.CNT_W(2)) dut2 (
      .clk(clk), .rst(rst), .din(din), .din_valid(din_valid),
      .overlap_en(overlap_en), .clr_cnt(clr_cnt),
      .detect(detect2), .state(state2), .det_count(count2), .cnt_sat(sat2)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Inputs change on the falling edge; outputs are read 1 time unit after the rising edge.
   task automatic drive(input logic d, input logic v, input logic ov, input logic c);
      @(negedge clk);
      din        = d;
      din_valid  = v;
      overlap_en = ov;
      clr_cnt    = c;
      @(posedge clk);
      #1;
   endtask

   function automatic void add(input logic d, input logic v, input logic ov, input logic c,
                               input logic det, input logic [1:0] st, input int cnt);
      vec_t r;
      r.d = d; r.v = v; r.ov = ov; r.clr = c;
      r.exp_det = det; r.exp_st = st; r.exp_cnt = cnt;
      tbl.push_back(r);
   endfunction

   initial begin
      int nm;
      int exp_c2;

      // Overlap on: 1011011 -> matches on bits 4 and 7
      add(1,1,1,0, 0,2'd1,0);
      add(0,1,1,0, 0,2'd2,0);
      add(1,1,1,0, 0,2'd3,0);
      add(1,1,1,0, 1,2'd1,1);
      add(0,1,1,0, 0,2'd2,1);
      add(1,1,1,0, 0,2'd3,1);
      add(1,1,1,0, 1,2'd1,2);
      add(0,1,1,0, 0,2'd2,2);
      add(0,1,1,0, 0,2'd0,2);
      // Overlap off: same stream -> one match, restart in IDLE
      add(1,1,0,0, 0,2'd1,2);
      add(0,1,0,0, 0,2'd2,2);
      add(1,1,0,0, 0,2'd3,2);
      add(1,1,0,0, 1,2'd0,3);
      add(0,1,0,0, 0,2'd0,3);
      add(1,1,0,0, 0,2'd1,3);
      add(1,1,0,0, 0,2'd1,3);
      add(0,1,0,0, 0,2'd2,3);
      add(0,1,0,0, 0,2'd0,3);
      // Valid gaps: din and overlap_en wiggle while invalid, state holds
      add(1,1,1,0, 0,2'd1,3);
      add(1,0,0,0, 0,2'd1,3);
      add(0,1,1,0, 0,2'd2,3);
      add(1,1,1,0, 0,2'd3,3);
      add(1,0,0,0, 0,2'd3,3);
      add(0,0,1,0, 0,2'd3,3);
      add(1,0,0,0, 0,2'd3,3);
      add(1,1,1,0, 1,2'd1,4);
      add(1,0,1,0, 0,2'd1,4);
      // Clear colliding with a match, then counting resumes
      add(0,1,1,0, 0,2'd2,4);
      add(1,1,0,0, 0,2'd3,4);
      add(1,1,1,1, 1,2'd1,0);
      add(0,1,1,0, 0,2'd2,0);
      add(1,1,1,0, 0,2'd3,0);
      add(1,1,0,0, 1,2'd0,1);
      add(0,0,0,1, 0,2'd0,0);
      add(1,1,1,0, 0,2'd1,0);
      add(0,1,1,0, 0,2'd2,0);
      add(1,1,1,0, 0,2'd3,0);
      add(1,1,1,0, 1,2'd1,1);

      // Reset state
      #12;
      chk("reset_state", state8, 0);
      chk("reset_detect", detect8, 0);
      chk("reset_count", count8, 0);
      chk("reset_sat", sat8, 0);
      @(negedge clk);
      rst = 1'b1;

      foreach (tbl[i]) begin
         drive(tbl[i].d, tbl[i].v, tbl[i].ov, tbl[i].clr);
         chk($sformatf("vec%0d_detect", i), detect8, tbl[i].exp_det);
         chk($sformatf("vec%0d_state", i), state8, tbl[i].exp_st);
         chk($sformatf("vec%0d_count", i), count8, tbl[i].exp_cnt);
         chk($sformatf("vec%0d_sat", i), sat8, 0);
      end

      // Reset mid-pattern: from S1, 0 then 1 reaches S101
      drive(0,1,1,0);
      drive(1,1,1,0);
      chk("mid_pre_state", state8, 3);
      chk("mid_pre_count", count8, 1);
      #2;
      rst = 1'b0;
      #1;
      chk("mid_async_state", state8, 0);
      chk("mid_async_detect", detect8, 0);
      chk("mid_async_count", count8, 0);
      drive(1,1,1,0);
      chk("mid_hold_state", state8, 0);
      chk("mid_hold_detect", detect8, 0);
      chk("mid_hold_count", count8, 0);
      @(negedge clk);
      din_valid = 1'b0;
      rst = 1'b1;
      drive(1,1,1,0);
      chk("mid_after_detect", detect8, 0);
      chk("mid_after_state", state8, 1);
      chk("mid_after_count", count8, 0);

      // Saturation on the 2-bit counter: five overlapped matches
      @(negedge clk);
      rst = 1'b0;
      din_valid = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      nm = 0;
      for (int k = 1; k <= 16; k++) begin
         logic bit_v;
         logic m;
         bit_v = ((k % 3) != 2);
         m = (k >= 4) && ((k % 3) == 1);
         if (m) nm++;
         exp_c2 = (nm > 3) ? 3 : nm;
         drive(bit_v, 1, 1, 0);
         chk($sformatf("sat_bit%0d_detect", k), detect2, m);
         chk($sformatf("sat_bit%0d_count", k), count2, exp_c2);
         chk($sformatf("sat_bit%0d_sat", k), sat2, (nm >= 3));
      end
      chk("sat_wide_count", count8, 5);
      chk("sat_wide_sat", sat8, 0);
      drive(0,1,1,1);
      chk("sat_clear_count", count2, 0);
      chk("sat_clear_sat", sat2, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
